// File: rtl/fetch_prefetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit_pkg
// Description : Shared defaults and helpers for the instruction-fetch stage
//               with prefetch queue (PC step, reset PC, NOP encoding, counter
//               width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_prefetch_unit_pkg;

    localparam int unsigned c_PC_STEP_DEFAULT  = 4;
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] c_NOP_INSN         = 32'h0000_0013;

    // Width needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sync_fifo
// Description : Synchronous FIFO holding {pc, instruction} entries for the
//               fetch stage. Head is read combinationally (first-word view).
//               Flush empties the queue in one cycle and wins over push/pop.
//               A push on a full queue is accepted only together with a pop.
// Ports       : clk, rst (async, active-low)
//               flush_i, push_i, push_data_i, pop_i  - control / write data
//               head_data_o                          - oldest entry
//               count_o, full_o, empty_o             - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sync_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CW'(DEPTH));
    assign count_o     = count_q;
    assign head_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction-fetch stage with decoupled prefetch queue.
//               Issues sequential PC requests to a pipelined in-order
//               instruction memory, buffers returned words with their PC and
//               presents {pc, npc, ir} to ID. Redirects flush the queue and
//               discard responses that were already in flight.
// Ports       : clk, rst (async, active-low)
//               redirect_valid/redirect_pc           - branch/jump redirect
//               imem_req_valid/ready/addr            - fetch request
//               imem_rsp_valid/data                  - fetch response
//               if_valid/if_ready/if_pc/if_npc/if_ir - toward ID
//               inflight                             - outstanding requests
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC_DEFAULT),
    parameter int unsigned     PC_STEP  = c_PC_STEP_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [XLEN-1:0]              imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [ILEN-1:0]              imem_rsp_data,
    output logic                         if_valid,
    input  logic                         if_ready,
    output logic [XLEN-1:0]              if_pc,
    output logic [XLEN-1:0]              if_npc,
    output logic [ILEN-1:0]              if_ir,
    output logic [cnt_width(DEPTH)-1:0]  inflight
);

    localparam int CW = cnt_width(DEPTH);
    localparam int SW = CW + 1;

    logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]      rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]        q_count;
    logic                 q_full;
    logic                 q_empty;
    logic [XLEN+ILEN-1:0] q_head;
    logic [SW-1:0]        credit_used;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 q_push;
    logic                 q_pop;
    logic [XLEN-1:0]      head_pc;

    // Queued words plus outstanding fetches never exceed DEPTH, so every
    // response is guaranteed a free queue slot. The rst term keeps the
    // request low while reset is held.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, q_count};
    assign imem_req_valid = rst && !redirect_valid && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and ignored.
    assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
    assign q_push   = rsp_fire && (drop_cnt_q == '0) && !redirect_valid
                      && (!q_full || q_pop);
    assign q_pop    = if_valid && if_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the
            // old stream and must be discarded when it returns.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = inflight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (rsp_fire) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_sync_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (q_push),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .pop_i       (q_pop),
        .head_data_o (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // Outputs read zero whenever no instruction is presented.
    assign if_valid = !q_empty;
    assign head_pc  = q_head[XLEN+ILEN-1:ILEN];
    assign if_pc    = if_valid ? head_pc                   : '0;
    assign if_npc   = if_valid ? head_pc + XLEN'(PC_STEP)  : '0;
    assign if_ir    = if_valid ? q_head[ILEN-1:0]          : '0;
    assign inflight = inflight_q;

endmodule
`default_nettype wire
